// File: rtl/ibex_mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto a single OBI-style memory port.
// Tracks outstanding grants in an ID FIFO so responses route back in grant order.
module ibex_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic [6:0]  instr_rdata_intg_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic [31:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [6:0]  mem_wdata_intg_o,
  input  logic [31:0] mem_rdata_i,
  input  logic [6:0]  mem_rdata_intg_i,
  input  logic        mem_err_i,

  output logic        spurious_rvalid_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_e;

  state_e                    r_state;
  state_e                    w_state_next;
  logic                      r_prio_data;
  logic [CntW-1:0]           r_count;
  logic [PtrW-1:0]           r_wptr;
  logic [PtrW-1:0]           r_rptr;
  logic [MaxOutstanding-1:0] r_fifo;
  logic                      r_spurious;

  logic w_sel_data;
  logic w_sel_req;
  logic w_full;
  logic w_can_issue;
  logic w_mem_req;
  logic w_grant;
  logic w_pop;
  logic w_head_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A lock pins the selection; in IDLE a tie goes to whoever did not win last.
  always_comb begin
    w_sel_data = 1'b0;
    unique case (r_state)
      LOCK_I:  w_sel_data = 1'b0;
      LOCK_D:  w_sel_data = 1'b1;
      default: w_sel_data = data_req_i & (~instr_req_i | r_prio_data);
    endcase
    w_sel_req = w_sel_data ? data_req_i : instr_req_i;
  end

  // A same-cycle response frees a slot, so a full FIFO can still issue.
  assign w_full      = (r_count == CntW'(MaxOutstanding));
  assign w_can_issue = ~w_full | mem_rvalid_i;
  assign w_mem_req   = ~rst_i & w_sel_req & w_can_issue;
  assign w_grant     = w_mem_req & mem_gnt_i;
  assign w_pop       = ~rst_i & mem_rvalid_i & (r_count != '0);
  assign w_head_data = r_fifo[r_rptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_mem_req && !mem_gnt_i) w_state_next = w_sel_data ? LOCK_D : LOCK_I;
      end
      LOCK_I, LOCK_D: begin
        if (w_grant) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o          = w_mem_req;
    instr_gnt_o        = w_grant & ~w_sel_data;
    data_gnt_o         = w_grant & w_sel_data;
    mem_we_o           = 1'b0;
    mem_be_o           = 4'hF;
    mem_addr_o         = instr_addr_i;
    mem_wdata_o        = '0;
    mem_wdata_intg_o   = '0;
    if (w_sel_data) begin
      mem_we_o         = data_we_i;
      mem_be_o         = data_be_i;
      mem_addr_o       = data_addr_i;
      mem_wdata_o      = data_wdata_i;
      mem_wdata_intg_o = data_wdata_intg_i;
    end
  end

  // Response routing: only the head source sees rvalid and payload.
  always_comb begin
    instr_rvalid_o     = w_pop & ~w_head_data;
    data_rvalid_o      = w_pop & w_head_data;
    instr_rdata_o      = '0;
    instr_rdata_intg_o = '0;
    instr_err_o        = 1'b0;
    data_rdata_o       = '0;
    data_rdata_intg_o  = '0;
    data_err_o         = 1'b0;
    if (instr_rvalid_o) begin
      instr_rdata_o      = mem_rdata_i;
      instr_rdata_intg_o = mem_rdata_intg_i;
      instr_err_o        = mem_err_i;
    end
    if (data_rvalid_o) begin
      data_rdata_o      = mem_rdata_i;
      data_rdata_intg_o = mem_rdata_intg_i;
      data_err_o        = mem_err_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio_data <= 1'b1;
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fifo      <= '0;
      r_spurious  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_fifo[r_wptr] <= w_sel_data;
        r_wptr         <= ptr_inc(r_wptr);
        r_prio_data    <= ~w_sel_data;
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      if (w_grant && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_grant && w_pop) r_count <= r_count - CntW'(1);
      if (mem_rvalid_i && (r_count == '0)) r_spurious <= 1'b1;
    end
  end

  assign spurious_rvalid_o = r_spurious;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed bench for ibex_mem_arbiter: inputs change on the falling edge,
// outputs are checked 1ns later, and the rising edge commits each step.
module tb_ibex_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic [6:0]  instr_rdata_intg_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [6:0]  data_wdata_intg_i, data_rdata_intg_o;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [6:0]  mem_wdata_intg_o, mem_rdata_intg_i;
  logic        spurious_rvalid_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ibex_mem_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
    .instr_rdata_intg_o(instr_rdata_intg_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_wdata_intg_i(data_wdata_intg_i),
    .data_rdata_o(data_rdata_o), .data_rdata_intg_o(data_rdata_intg_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wdata_intg_o(mem_wdata_intg_o),
    .mem_rdata_i(mem_rdata_i), .mem_rdata_intg_i(mem_rdata_intg_i), .mem_err_i(mem_err_i),
    .spurious_rvalid_o(spurious_rvalid_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    instr_req_i = 0; instr_addr_i = 32'h0;
    data_req_i = 0; data_we_i = 0; data_be_i = 4'h0; data_addr_i = 32'h0;
    data_wdata_i = 32'h0; data_wdata_intg_i = 7'h0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 32'h0; mem_rdata_intg_i = 7'h0; mem_err_i = 0;
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();

    // Reset: outputs held low even with every input asserted
    step(); rst_i = 1; instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1; #1;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_igrant", instr_gnt_o, 0);
    chk("rst_dgrant", data_gnt_o, 0);
    chk("rst_irv", instr_rvalid_o, 0);
    chk("rst_drv", data_rvalid_o, 0);
    step(); #1;
    chk("rst_spur", spurious_rvalid_o, 0);

    // Single data read, response two cycles after grant
    step(); rst_i = 0; idle_inputs(); data_req_i = 1; data_addr_i = 32'h100; data_be_i = 4'hF; mem_gnt_i = 1; #1;
    chk("rd_mem_req", mem_req_o, 1);
    chk("rd_addr", mem_addr_o, 32'h100);
    chk("rd_dgnt", data_gnt_o, 1);
    chk("rd_ignt", instr_gnt_o, 0);
    step(); idle_inputs(); #1;
    chk("rd_gap_req", mem_req_o, 0);
    chk("rd_gap_dgnt", data_gnt_o, 0);
    step(); mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; mem_rdata_intg_i = 7'h55; #1;
    chk("rd_drv", data_rvalid_o, 1);
    chk("rd_rdata", data_rdata_o, 32'hDEADBEEF);
    chk("rd_intg", data_rdata_intg_o, 7'h55);
    chk("rd_irv", instr_rvalid_o, 0);
    chk("rd_irdata_zero", instr_rdata_o, 0);
    step(); idle_inputs(); #1;
    chk("rd_drv_off", data_rvalid_o, 0);
    chk("rd_rdata_zero", data_rdata_o, 0);

    // Round-robin from reset: D,I,D,I grants with in-order responses
    step(); rst_i = 1; #1;
    step(); rst_i = 0; instr_req_i = 1; data_req_i = 1; instr_addr_i = 32'h200; data_addr_i = 32'h300; mem_gnt_i = 1; #1;
    chk("rr0_dgnt", data_gnt_o, 1);
    chk("rr0_ignt", instr_gnt_o, 0);
    chk("rr0_addr", mem_addr_o, 32'h300);
    step(); mem_rvalid_i = 1; mem_rdata_i = 32'hB0000001; #1;
    chk("rr1_ignt", instr_gnt_o, 1);
    chk("rr1_addr", mem_addr_o, 32'h200);
    chk("rr1_drv", data_rvalid_o, 1);
    chk("rr1_drdata", data_rdata_o, 32'hB0000001);
    chk("rr1_irv", instr_rvalid_o, 0);
    step(); mem_rdata_i = 32'hB0000002; #1;
    chk("rr2_dgnt", data_gnt_o, 1);
    chk("rr2_irv", instr_rvalid_o, 1);
    chk("rr2_irdata", instr_rdata_o, 32'hB0000002);
    chk("rr2_drv", data_rvalid_o, 0);
    step(); mem_rdata_i = 32'hB0000003; #1;
    chk("rr3_ignt", instr_gnt_o, 1);
    chk("rr3_drv", data_rvalid_o, 1);
    chk("rr3_drdata", data_rdata_o, 32'hB0000003);
    step(); instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rdata_i = 32'hB0000004; #1;
    chk("rr4_req", mem_req_o, 0);
    chk("rr4_irv", instr_rvalid_o, 1);
    chk("rr4_irdata", instr_rdata_o, 32'hB0000004);
    chk("rr4_drv", data_rvalid_o, 0);

    // Instr lock under backpressure while data request rises
    step(); idle_inputs(); instr_req_i = 1; instr_addr_i = 32'h80;
    data_we_i = 1; data_be_i = 4'h3; data_addr_i = 32'h400; data_wdata_i = 32'hCAFE; data_wdata_intg_i = 7'h2A; #1;
    chk("lk0_req", mem_req_o, 1);
    chk("lk0_addr", mem_addr_o, 32'h80);
    chk("lk0_be", mem_be_o, 4'hF);
    chk("lk0_ignt", instr_gnt_o, 0);
    step(); data_req_i = 1; #1;
    chk("lk1_addr", mem_addr_o, 32'h80);
    chk("lk1_we", mem_we_o, 0);
    chk("lk1_wdata", mem_wdata_o, 0);
    chk("lk1_dgnt", data_gnt_o, 0);
    step(); #1;
    chk("lk2_addr", mem_addr_o, 32'h80);
    step(); mem_gnt_i = 1; #1;
    chk("lk3_addr", mem_addr_o, 32'h80);
    chk("lk3_ignt", instr_gnt_o, 1);
    chk("lk3_dgnt", data_gnt_o, 0);
    step(); instr_req_i = 0; #1;
    chk("lk4_dgnt", data_gnt_o, 1);
    chk("lk4_addr", mem_addr_o, 32'h400);
    chk("lk4_we", mem_we_o, 1);
    chk("lk4_be", mem_be_o, 4'h3);
    chk("lk4_wdata", mem_wdata_o, 32'hCAFE);
    chk("lk4_wintg", mem_wdata_intg_o, 7'h2A);
    step(); data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'h11; #1;
    chk("lk5_irv", instr_rvalid_o, 1);
    chk("lk5_ierr", instr_err_o, 1);
    chk("lk5_derr", data_err_o, 0);
    step(); mem_err_i = 0; mem_rdata_i = 32'h22; #1;
    chk("lk6_drv", data_rvalid_o, 1);
    chk("lk6_drdata", data_rdata_o, 32'h22);

    // Outstanding limit of 2, then grant+pop in one cycle while full
    step(); idle_inputs(); data_req_i = 1; data_addr_i = 32'h500; mem_gnt_i = 1; #1;
    chk("fl0_dgnt", data_gnt_o, 1);
    step(); #1;
    chk("fl1_dgnt", data_gnt_o, 1);
    step(); #1;
    chk("fl2_req", mem_req_o, 0);
    chk("fl2_dgnt", data_gnt_o, 0);
    step(); mem_rvalid_i = 1; mem_rdata_i = 32'h33; #1;
    chk("fl3_req", mem_req_o, 1);
    chk("fl3_dgnt", data_gnt_o, 1);
    chk("fl3_drv", data_rvalid_o, 1);
    step(); mem_rvalid_i = 0; #1;
    chk("fl4_req_still_full", mem_req_o, 0);
    step(); data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; #1;
    chk("fl5_drv", data_rvalid_o, 1);
    step(); #1;
    chk("fl6_drv", data_rvalid_o, 1);

    // Spurious response with nothing outstanding
    step(); mem_rdata_i = 32'h44; #1;
    chk("sp_irv", instr_rvalid_o, 0);
    chk("sp_drv", data_rvalid_o, 0);
    chk("sp_drdata", data_rdata_o, 0);
    step(); mem_rvalid_i = 0; #1;
    chk("sp_set", spurious_rvalid_o, 1);
    step(); #1;
    chk("sp_sticky", spurious_rvalid_o, 1);

    // Reset with one outstanding and an active instr lock
    step(); idle_inputs(); instr_req_i = 1; instr_addr_i = 32'h600; data_addr_i = 32'h700; mem_gnt_i = 1; #1;
    chk("rl0_ignt", instr_gnt_o, 1);
    step(); mem_gnt_i = 0; #1;
    chk("rl1_req", mem_req_o, 1);
    step(); data_req_i = 1; #1;
    chk("rl2_lock_addr", mem_addr_o, 32'h600);
    step(); rst_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1; #1;
    chk("rl3_req", mem_req_o, 0);
    chk("rl3_ignt", instr_gnt_o, 0);
    chk("rl3_irv", instr_rvalid_o, 0);
    step(); rst_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; #1;
    chk("rl4_spur_clr", spurious_rvalid_o, 0);
    chk("rl4_req", mem_req_o, 1);
    chk("rl4_addr", mem_addr_o, 32'h700);
    step(); mem_gnt_i = 1; mem_rvalid_i = 1; #1;
    chk("rl5_dgnt", data_gnt_o, 1);
    chk("rl5_irv", instr_rvalid_o, 0);
    chk("rl5_drv", data_rvalid_o, 0);
    step(); idle_inputs(); #1;
    chk("rl6_spur", spurious_rvalid_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_mem_arbiter.md
IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, meaning the maximum number of granted transactions awaiting rvalid (legal range 1-4).
REQ-002 SHALL have port clk_i input 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i input 1: reset, synchronous and active-high.
REQ-004 SHALL have instruction-side ports:
- instr_req_i input 1
- instr_gnt_o output 1
- instr_rvalid_o output 1
- instr_addr_i input 32
- instr_rdata_o output 32
- instr_rdata_intg_o output 7
- instr_err_o output 1
REQ-005 SHALL have data-side ports:
- data_req_i input 1
- data_gnt_o output 1
- data_rvalid_o output 1
- data_we_i input 1
- data_be_i input 4
- data_addr_i input 32
- data_wdata_i input 32
- data_wdata_intg_i input 7
- data_rdata_o output 32
- data_rdata_intg_o output 7
- data_err_o output 1
REQ-006 SHALL have memory-side ports:
- mem_req_o output 1
- mem_gnt_i input 1
- mem_rvalid_i input 1
- mem_we_o output 1
- mem_be_o output 4
- mem_addr_o output 32
- mem_wdata_o output 32
- mem_wdata_intg_o output 7
- mem_rdata_i input 32
- mem_rdata_intg_i input 7
- mem_err_i input 1
REQ-007 SHALL have port spurious_rvalid_o output 1: sticky flag, set when mem_rvalid_i arrives with nothing outstanding.

Function
REQ-008 SHALL arbitrate between instr_req_i and data_req_i using states IDLE, LOCK_I and LOCK_D.
REQ-009 In IDLE with exactly one requester, SHALL select that requester; with both, SHALL select the one that did not win the previous grant (round-robin bit; reset value selects data first).
REQ-010 SHALL drive mem_req_o high combinationally in the same cycle the selected requester's req is high, unless the outstanding count equals MaxOutstanding.
REQ-011 SHALL drive the mem_* command fields from the selected requester. For an instruction request: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0, mem_wdata_intg_o=0.
REQ-012 If mem_req_o is high and mem_gnt_i is low, SHALL transition to LOCK_I or LOCK_D and hold the selection, keeping all mem_* fields stable until mem_gnt_i.
REQ-013 On mem_gnt_i with mem_req_o high, SHALL:
- assert the selected side's gnt_o in that cycle, with the other side's gnt_o low;
- push the source ID (0=instr, 1=data) into the outstanding FIFO;
- update the round-robin bit;
- return to IDLE.
REQ-014 SHALL keep the outstanding FIFO at depth MaxOutstanding with a count register of width $clog2(MaxOutstanding+1); when full, mem_req_o stays low and any lock is held.
REQ-015 On mem_rvalid_i with count>0, SHALL:
- pop the FIFO head;
- assert rvalid_o of the head source only, in the same cycle;
- forward mem_rdata_i, mem_rdata_intg_i and mem_err_i to that side's rdata/intg/err outputs.
REQ-016 A simultaneous grant and rvalid in one cycle SHALL push and pop together, leaving the count unchanged, including when the FIFO is full.
REQ-017 mem_rvalid_i with count=0 SHALL be dropped (no rvalid_o) and SHALL set spurious_rvalid_o, which stays high until reset.
REQ-018 When no grant is issued, gnt_o outputs SHALL be low. When no rvalid is routed to a side, its rvalid_o SHALL be low and its rdata/intg/err outputs SHALL be 0.
REQ-019 Responses SHALL be returned in grant order. FIFO pointers SHALL wrap modulo MaxOutstanding.

Reset
REQ-020 While rst_i is high: state=IDLE, count=0, FIFO pointers=0, round-robin bit selects data, spurious_rvalid_o=0, mem_req_o=0, all gnt_o=0, all rvalid_o=0.
REQ-021 Reset mid-transaction SHALL discard the lock and all outstanding IDs. rvalids arriving after reset SHALL be treated per REQ-017.

Verification
REQ-022 Single data read at addr 32'h100, gnt immediate, rvalid 2 cycles later with rdata 32'hDEADBEEF -> data_gnt_o same cycle, data_rvalid_o with 32'hDEADBEEF, instr_rvalid_o stays 0.
REQ-023 Both requesters high from reset, mem_gnt_i always 1 -> grants alternate D,I,D,I over 4 cycles; rvalids return routed D,I,D,I.
REQ-024 Instr request at 32'h80 with mem_gnt_i held low 3 cycles while data_req_i rises in cycle 1 -> mem_addr_o stays 32'h80 for all 4 cycles; the instr grant comes first, then the data grant.
REQ-025 MaxOutstanding=2, two grants with no rvalid -> mem_req_o=0 on the third request; a rvalid in the same cycle as a pending request -> grant and pop in that cycle, count stays 2.
REQ-026 mem_rvalid_i pulse with count=0 -> no rvalid_o on either side, spurious_rvalid_o=1 until rst_i.
REQ-027 rst_i asserted with 1 outstanding and an active lock -> next cycle count=0, state=IDLE, mem_req_o follows the fresh arbitration.
